// File: rtl/dl_ac_pkg.sv
// Shared types for the 60M DL antenna-calibration scheduler: FSM encoding and next-antenna lookup.
package dl_ac_pkg;

    localparam int unsigned ANT_NUM = 8;

    typedef enum logic [2:0] {
        StIdle,
        StWaitOfs,
        StSeq,
        StGap,
        StDone
    } ac_state_e;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } ant_lookup_t;

    // Lowest set mask bit strictly above cur; found=0 when none remain.
    function automatic ant_lookup_t next_ant(input logic [ANT_NUM-1:0] mask,
                                             input logic [2:0]         cur);
        ant_lookup_t res;
        res.found = 1'b0;
        res.idx   = cur;
        for (int i = ANT_NUM - 1; i >= 0; i--) begin
            if (i > int'(cur) && mask[i]) begin
                res.found = 1'b1;
                res.idx   = 3'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ac_rx_delay_line.sv
// Fixed-latency delay of the TX sequence-valid strobe towards the RX side, with synchronous flush.
module ac_rx_delay_line #(
    parameter int unsigned DEPTH = 16
) (
    input  logic clk,
    input  logic asy_rst,
    input  logic flush,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] din_ext;

    always_comb begin
        din_ext    = '0;
        din_ext[0] = din;
    end

    always_ff @(posedge clk or negedge asy_rst) begin
        if (!asy_rst) begin
            sr_q <= '0;
        end else if (flush) begin
            sr_q <= '0;
        end else begin
            sr_q <= (sr_q << 1) | din_ext;
        end
    end

    assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/dl_ac_seq_sched_60m.sv
// DL antenna-calibration sequence scheduler (60M path). Optional RX strobe delay: AC_SCHED_RX_EN.
// Start offset N means the (N+1)-th tick after the arming header emits the first sample.
module dl_ac_seq_sched_60m
    import dl_ac_pkg::*;
#(
    parameter int unsigned SEQ_LEN   = 80,
    parameter int unsigned GAP_TICKS = 4,
    parameter int unsigned RX_LAT    = 16
) (
    input  logic        clk,
    input  logic        asy_rst,
    input  logic        i_fram_hd,
    input  logic        i_ant8_sel,
    input  logic        i_cal_en,
    input  logic [7:0]  reg_cal_period,
    input  logic [15:0] reg_start_ofs,
    input  logic [7:0]  reg_cal_ant_mask,
    output logic        o_tx_ac_valid,
    output logic        o_tx_seq_valid,
    output logic        o_rx_seq_valid,
    output logic [2:0]  o_ant_cnt,
    output logic [6:0]  o_seq_cnt,
    output logic [3:0]  o_group_index,
    output logic        o_cal_done,
    output logic        o_cal_abort,
    output logic        o_busy
);

    localparam logic [6:0] SEQ_LAST = 7'(SEQ_LEN - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_TICKS - 1);

    ac_state_e   state_q, state_d;
    logic [7:0]  frm_cnt_q, frm_cnt_d;
    logic [15:0] ofs_q, ofs_d, ofs_cnt_q, ofs_cnt_d;
    logic [7:0]  mask_q, mask_d, gap_cnt_q, gap_cnt_d;
    logic        ac_q, ac_d, seq_vld_q, seq_vld_d, done_q, done_d, abort_q, abort_d;
    logic [2:0]  ant_q, ant_d;
    logic [6:0]  seq_cnt_q, seq_cnt_d;
    logic [3:0]  grp_q, grp_d;
    logic        arm, abort_req;
    ant_lookup_t nxt, low;

    always_comb begin
        state_d   = state_q;
        frm_cnt_d = frm_cnt_q;
        ofs_d     = ofs_q;
        mask_d    = mask_q;
        ofs_cnt_d = ofs_cnt_q;
        gap_cnt_d = gap_cnt_q;
        ac_d      = ac_q;
        seq_vld_d = seq_vld_q;
        ant_d     = ant_q;
        seq_cnt_d = seq_cnt_q;
        grp_d     = grp_q;
        done_d    = 1'b0;
        abort_d   = 1'b0;
        nxt       = next_ant(mask_q, ant_q);
        low       = next_ant(mask_q, 3'd0);
        arm       = i_fram_hd && (frm_cnt_q == 8'd0) && i_cal_en &&
                    (reg_cal_period != 8'd0) && (reg_cal_ant_mask != 8'd0);
        abort_req = i_fram_hd || !i_cal_en;

        // Every header counts, including one that aborts a run.
        if (i_fram_hd) begin
            if (reg_cal_period <= 8'd1 || frm_cnt_q >= reg_cal_period - 8'd1) begin
                frm_cnt_d = 8'd0;
            end else begin
                frm_cnt_d = frm_cnt_q + 8'd1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (arm) begin
                    state_d   = StWaitOfs;
                    ofs_d     = reg_start_ofs;
                    mask_d    = reg_cal_ant_mask;
                    ofs_cnt_d = 16'd0;
                end
            end
            StWaitOfs, StSeq, StGap: begin
                if (abort_req) begin
                    state_d   = StIdle;
                    abort_d   = 1'b1;
                    ac_d      = 1'b0;
                    seq_vld_d = 1'b0;
                    ant_d     = 3'd0;
                    seq_cnt_d = 7'd0;
                end else if (i_ant8_sel) begin
                    if (state_q == StWaitOfs) begin
                        if (ofs_cnt_q == ofs_q) begin
                            state_d   = StSeq;
                            ac_d      = 1'b1;
                            seq_vld_d = 1'b1;
                            seq_cnt_d = 7'd0;
                            ant_d     = mask_q[0] ? 3'd0 : low.idx;
                        end else begin
                            ofs_cnt_d = ofs_cnt_q + 16'd1;
                        end
                    end else if (state_q == StSeq) begin
                        if (seq_cnt_q != SEQ_LAST) begin
                            seq_cnt_d = seq_cnt_q + 7'd1;
                        end else if (!nxt.found) begin
                            state_d   = StDone;
                            done_d    = 1'b1;
                            grp_d     = grp_q + 4'd1;
                            ac_d      = 1'b0;
                            seq_vld_d = 1'b0;
                            ant_d     = 3'd0;
                            seq_cnt_d = 7'd0;
                        end else if (GAP_TICKS == 0) begin
                            ant_d     = nxt.idx;
                            seq_cnt_d = 7'd0;
                        end else begin
                            state_d   = StGap;
                            seq_vld_d = 1'b0;
                            seq_cnt_d = 7'd0;
                            gap_cnt_d = 8'd0;
                        end
                    end else begin
                        if (gap_cnt_q == GAP_LAST) begin
                            state_d   = StSeq;
                            seq_vld_d = 1'b1;
                            seq_cnt_d = 7'd0;
                            ant_d     = nxt.idx;
                        end else begin
                            gap_cnt_d = gap_cnt_q + 8'd1;
                        end
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge asy_rst) begin
        if (!asy_rst) begin
            state_q   <= StIdle;
            frm_cnt_q <= 8'd0;
            ofs_q     <= 16'd0;
            mask_q    <= 8'd0;
            ofs_cnt_q <= 16'd0;
            gap_cnt_q <= 8'd0;
            ac_q      <= 1'b0;
            seq_vld_q <= 1'b0;
            ant_q     <= 3'd0;
            seq_cnt_q <= 7'd0;
            grp_q     <= 4'd0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            frm_cnt_q <= frm_cnt_d;
            ofs_q     <= ofs_d;
            mask_q    <= mask_d;
            ofs_cnt_q <= ofs_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            ac_q      <= ac_d;
            seq_vld_q <= seq_vld_d;
            ant_q     <= ant_d;
            seq_cnt_q <= seq_cnt_d;
            grp_q     <= grp_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
        end
    end

    assign o_tx_ac_valid  = ac_q;
    assign o_tx_seq_valid = seq_vld_q;
    assign o_ant_cnt      = ant_q;
    assign o_seq_cnt      = seq_cnt_q;
    assign o_group_index  = grp_q;
    assign o_cal_done     = done_q;
    assign o_cal_abort    = abort_q;
    assign o_busy         = (state_q != StIdle);

`ifdef AC_SCHED_RX_EN
    ac_rx_delay_line #(
        .DEPTH(RX_LAT)
    ) u_rx_delay (
        .clk    (clk),
        .asy_rst(asy_rst),
        .flush  (abort_d),
        .din    (seq_vld_q),
        .dout   (o_rx_seq_valid)
    );
`else
    logic unused_rx_lat;
    assign unused_rx_lat  = ^RX_LAT;
    assign o_rx_seq_valid = 1'b0;
`endif

endmodule

// File: tb/tb_dl_ac_seq_sched_60m.sv
// Directed bench for dl_ac_seq_sched_60m with SEQ_LEN=4, GAP_TICKS=2, ticks every 8 clocks.
module tb_dl_ac_seq_sched_60m;

    logic        clk = 1'b0;
    logic        asy_rst;
    logic        i_fram_hd, i_ant8_sel, i_cal_en;
    logic [7:0]  reg_cal_period, reg_cal_ant_mask;
    logic [15:0] reg_start_ofs;
    logic        o_tx_ac_valid, o_tx_seq_valid, o_rx_seq_valid;
    logic [2:0]  o_ant_cnt;
    logic [6:0]  o_seq_cnt;
    logic [3:0]  o_group_index;
    logic        o_cal_done, o_cal_abort, o_busy;

    int n_chk  = 0;
    int n_fail = 0;
    logic rx_model = 1'b0;
    logic mon_en   = 1'b0;
    logic viol     = 1'b0;

    always #5 clk = ~clk;

    dl_ac_seq_sched_60m #(
        .SEQ_LEN  (4),
        .GAP_TICKS(2),
        .RX_LAT   (16)
    ) dut (
        .clk             (clk),
        .asy_rst         (asy_rst),
        .i_fram_hd       (i_fram_hd),
        .i_ant8_sel      (i_ant8_sel),
        .i_cal_en        (i_cal_en),
        .reg_cal_period  (reg_cal_period),
        .reg_start_ofs   (reg_start_ofs),
        .reg_cal_ant_mask(reg_cal_ant_mask),
        .o_tx_ac_valid   (o_tx_ac_valid),
        .o_tx_seq_valid  (o_tx_seq_valid),
        .o_rx_seq_valid  (o_rx_seq_valid),
        .o_ant_cnt       (o_ant_cnt),
        .o_seq_cnt       (o_seq_cnt),
        .o_group_index   (o_group_index),
        .o_cal_done      (o_cal_done),
        .o_cal_abort     (o_cal_abort),
        .o_busy          (o_busy)
    );

`ifdef AC_SCHED_RX_EN
    logic [15:0] hist;
    always @(posedge clk or negedge asy_rst) begin
        if (!asy_rst) hist <= '0;
        else          hist <= {hist[14:0], o_tx_seq_valid};
    end
`endif

    always @(posedge clk) begin
        if (mon_en && (o_busy || o_cal_done || o_cal_abort)) viol <= 1'b1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic       hd;
        logic       sel;
        logic       ac;
        logic       sq;
        logic [2:0] ant;
        logic [6:0] sc;
        logic       done;
        logic       abort;
        logic       busy;
        logic [3:0] grp;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string name, input int ac, input int sq, input int ant,
                           input int sc, input int done, input int abort, input int busy,
                           input int grp);
        chk({name, ".ac"},    32'(o_tx_ac_valid),  ac);
        chk({name, ".seq"},   32'(o_tx_seq_valid), sq);
        chk({name, ".ant"},   32'(o_ant_cnt),      ant);
        chk({name, ".sc"},    32'(o_seq_cnt),      sc);
        chk({name, ".done"},  32'(o_cal_done),     done);
        chk({name, ".abort"}, 32'(o_cal_abort),    abort);
        chk({name, ".busy"},  32'(o_busy),         busy);
        chk({name, ".grp"},   32'(o_group_index),  grp);
`ifdef AC_SCHED_RX_EN
        if (rx_model) chk({name, ".rx"}, 32'(o_rx_seq_valid), 32'(hist[15]));
`else
        chk({name, ".rx"}, 32'(o_rx_seq_valid), 0);
`endif
    endtask

    task automatic cyc(input logic hd, input logic sel);
        @(negedge clk);
        i_fram_hd  = hd;
        i_ant8_sel = sel;
        @(posedge clk);
        #1;
        i_fram_hd  = 1'b0;
        i_ant8_sel = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0);
    endtask

    task automatic tick();
        idle(7);
        cyc(1'b0, 1'b1);
    endtask

    initial begin
        // period=2, ofs=3, mask=05: arm, 3 waiting ticks, ant0 0..3, 2 gap ticks, ant2 0..3, done.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 7'd0, 1'b0, 1'b0, 1'b1, 4'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 7'd0, 1'b0, 1'b0, 1'b1, 4'd0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 7'd0, 1'b0, 1'b0, 1'b1, 4'd0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 7'd0, 1'b0, 1'b0, 1'b1, 4'd0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 7'd0, 1'b0, 1'b0, 1'b1, 4'd0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 7'd1, 1'b0, 1'b0, 1'b1, 4'd0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 7'd2, 1'b0, 1'b0, 1'b1, 4'd0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 7'd3, 1'b0, 1'b0, 1'b1, 4'd0};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 7'd0, 1'b0, 1'b0, 1'b1, 4'd0};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 7'd0, 1'b0, 1'b0, 1'b1, 4'd0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 7'd0, 1'b0, 1'b0, 1'b1, 4'd0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 7'd1, 1'b0, 1'b0, 1'b1, 4'd0};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 7'd2, 1'b0, 1'b0, 1'b1, 4'd0};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd2, 7'd3, 1'b0, 1'b0, 1'b1, 4'd0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 7'd0, 1'b1, 1'b0, 1'b1, 4'd1};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0, 4'd1};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 7'd0, 1'b0, 1'b0, 1'b0, 4'd1};

        asy_rst          = 1'b0;
        i_fram_hd        = 1'b0;
        i_ant8_sel       = 1'b0;
        i_cal_en         = 1'b1;
        reg_cal_period   = 8'd2;
        reg_start_ofs    = 16'd3;
        reg_cal_ant_mask = 8'h05;
        #12;
        chk_out("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        asy_rst = 1'b1;

        rx_model = 1'b1;
        for (int i = 0; i < 17; i++) begin
            idle(7);
            cyc(vecs[i].hd, vecs[i].sel);
            chk_out($sformatf("vec%0d", i), int'(vecs[i].ac), int'(vecs[i].sq),
                    int'(vecs[i].ant), int'(vecs[i].sc), int'(vecs[i].done),
                    int'(vecs[i].abort), int'(vecs[i].busy), int'(vecs[i].grp));
        end
        rx_model = 1'b0;

        // Header during ant-2 SEQ, coinciding with a tick: abort wins.
        idle(7);
        cyc(1'b1, 1'b0);
        chk("t2.arm", 32'(o_busy), 1);
        for (int k = 0; k < 11; k++) tick();
        chk_out("t2.ant2", 1, 1, 2, 1, 0, 0, 1, 1);
        idle(3);
        cyc(1'b1, 1'b1);
        chk_out("t2.abort", 0, 0, 0, 0, 0, 1, 0, 1);
        cyc(1'b0, 1'b0);
        chk("t2.abort_pulse", 32'(o_cal_abort), 0);
`ifdef AC_SCHED_RX_EN
        chk("t2.rx_flush", 32'(o_rx_seq_valid), 0);
`endif
        for (int k = 0; k < 3; k++) tick();
        chk("t2.no_rearm", 32'(o_busy), 0);

        // period=1: every header lands on count 0, yet the aborting header must not re-arm.
        reg_cal_period = 8'd1;
        cyc(1'b1, 1'b0);
        chk("t2b.arm", 32'(o_busy), 1);
        tick();
        cyc(1'b1, 1'b0);
        chk_out("t2b.abort", 0, 0, 0, 0, 0, 1, 0, 1);
        idle(2);
        chk("t2b.no_rearm", 32'(o_busy), 0);

        // Dropping the enable also aborts.
        cyc(1'b1, 1'b0);
        chk("t2c.arm", 32'(o_busy), 1);
        i_cal_en = 1'b0;
        cyc(1'b0, 1'b0);
        chk_out("t2c.en_abort", 0, 0, 0, 0, 0, 1, 0, 1);
        i_cal_en = 1'b1;

        // Single antenna 7, zero offset: no gap visited.
        reg_cal_ant_mask = 8'h80;
        reg_start_ofs    = 16'd0;
        idle(2);
        cyc(1'b1, 1'b0);
        tick();
        chk_out("t3.first", 1, 1, 7, 0, 0, 0, 1, 1);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk_out($sformatf("t3.s%0d", k), 1, 1, 7, k, 0, 0, 1, 1);
        end
        tick();
        chk_out("t3.done", 0, 0, 0, 0, 1, 0, 1, 2);
        cyc(1'b0, 1'b0);
        chk_out("t3.idle", 0, 0, 0, 0, 0, 0, 0, 2);

        // No arm with empty mask or zero period.
        mon_en = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            reg_cal_ant_mask = (pass == 0) ? 8'h00 : 8'hFF;
            reg_cal_period   = (pass == 0) ? 8'd1  : 8'd0;
            for (int h = 0; h < 10; h++) begin
                cyc(1'b1, 1'b0);
                chk($sformatf("t4.p%0d.h%0d.busy", pass, h), 32'(o_busy), 0);
                tick();
            end
        end
        idle(1);
        mon_en = 1'b0;
        chk("t4.no_activity", 32'(viol), 0);

        // Mask change mid-run is ignored until the next arm.
        reg_cal_period   = 8'd1;
        reg_cal_ant_mask = 8'h03;
        cyc(1'b1, 1'b0);
        tick();
        chk_out("t5.a0", 1, 1, 0, 0, 0, 0, 1, 2);
        reg_cal_ant_mask = 8'hFF;
        for (int k = 0; k < 3; k++) tick();
        tick();
        chk_out("t5.gap", 1, 0, 0, 0, 0, 0, 1, 2);
        tick();
        tick();
        chk_out("t5.a1", 1, 1, 1, 0, 0, 0, 1, 2);
        for (int k = 0; k < 3; k++) tick();
        tick();
        chk_out("t5.done", 0, 0, 0, 0, 1, 0, 1, 3);

        idle(2);
        cyc(1'b1, 1'b0);
        for (int a = 0; a < 8; a++) begin
            if (a > 0) begin
                tick();
                chk_out($sformatf("t5b.gap%0d", a), 1, 0, a - 1, 0, 0, 0, 1, 3);
                tick();
            end
            tick();
            chk_out($sformatf("t5b.ant%0d", a), 1, 1, a, 0, 0, 0, 1, 3);
            for (int k = 0; k < 3; k++) tick();
            chk($sformatf("t5b.last%0d", a), 32'(o_seq_cnt), 3);
        end
        tick();
        chk_out("t5b.done", 0, 0, 0, 0, 1, 0, 1, 4);

        // Asynchronous reset in the middle of SEQ.
        reg_cal_ant_mask = 8'h01;
        idle(2);
        cyc(1'b1, 1'b0);
        tick();
        chk_out("t6.seq", 1, 1, 0, 0, 0, 0, 1, 4);
        #2;
        asy_rst = 1'b0;
        #1;
        chk_out("t6.async_rst", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        asy_rst = 1'b1;
        idle(3);
        chk("t6.post_busy", 32'(o_busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
